clk_period_meter: RTL and testbench

Measures the period and high time of a divided clock, in cycles of the reference clock `clk`. It is the receiving end of the general clock divider: the divider turns a load value into a waveform, and this block turns the waveform back into cycle counts. Its main uses are on-chip checking of divider outputs and closed-loop trimming. `sig_in` is treated as asynchronous and is synchronised internally.

---
 rtl/clk_period_meter.sv | 113 +++++++++++
 tb/tb_clk_period_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous divided clock in cycles of clk.
// A result is published, with a one-cycle valid_o pulse, on every rising edge after the first.
module clk_period_meter #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 meas_en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 timeout_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;
  logic                   sig_s;
  logic                   rise;
  logic                   fall;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   hcnt;
  logic [CNT_WIDTH-1:0]   hlat;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      hlat      <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      if (!meas_en) begin
        state <= IDLE;
        cnt   <= '0;
        hcnt  <= '0;
        hlat  <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;

          // The first rise only opens the measurement window.
          ARM: begin
            if (rise) begin
              state <= MEAS;
              cnt   <= CNT_ONE;
              hcnt  <= CNT_ONE;
            end
          end

          MEAS: begin
            // A rise on the saturation cycle still publishes the full-scale period.
            if (rise) begin
              period_o <= cnt;
              high_o   <= hlat;
              valid_o  <= 1'b1;
              cnt      <= CNT_ONE;
              hcnt     <= CNT_ONE;
            end else begin
              if (cnt == CNT_MAX) begin
                state     <= ARM;
                timeout_o <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
              if (sig_s && hcnt != CNT_MAX) begin
                hcnt <= hcnt + CNT_ONE;
              end
              if (fall) begin
                hlat <= hcnt;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: an 8-bit and a 4-bit instance share stimulus;
// a negedge monitor records every valid_o/timeout_o pulse with its cycle number.
module tb_clk_period_meter;

  logic       clk;
  logic       rst;
  logic       meas_en;
  logic       sig_in;
  logic [7:0] p8, h8;
  logic       v8, t8;
  logic [3:0] p4, h4;
  logic       v4, t4;

  clk_period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .meas_en(meas_en), .sig_in(sig_in),
    .period_o(p8), .high_o(h8), .valid_o(v8), .timeout_o(t8)
  );

  clk_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .meas_en(meas_en), .sig_in(sig_in),
    .period_o(p4), .high_o(h4), .valid_o(v4), .timeout_o(t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int p;
    int h;
  } ev_t;

  typedef struct {
    int h;
    int l;
    int n;
    int exp_p;
    int exp_h;
    int n4v;
    int n4t;
  } row_t;

  ev_t  q8[$];
  ev_t  q4[$];
  int   tq8[$];
  int   tq4[$];
  int   rise_q[$];
  ev_t  e8, e4;
  int   overlap = 0;
  int   runs = 0;
  logic pv8 = 1'b0, pt8 = 1'b0, pv4 = 1'b0, pt4 = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (v8) begin
      e8.cyc = cyc; e8.p = int'(p8); e8.h = int'(h8);
      q8.push_back(e8);
    end
    if (v4) begin
      e4.cyc = cyc; e4.p = int'(p4); e4.h = int'(h4);
      q4.push_back(e4);
    end
    if (t8) tq8.push_back(cyc);
    if (t4) tq4.push_back(cyc);
    if ((v8 && t8) || (v4 && t4)) overlap++;
    if ((v8 && pv8) || (t8 && pt8) || (v4 && pv4) || (t4 && pt4)) runs++;
    pv8 = v8; pt8 = t8; pv4 = v4; pt4 = t4;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_sig(input logic v);
    if (v && !sig_in) rise_q.push_back(cyc);
    sig_in = v;
  endtask

  task automatic drive_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      set_sig(1'b1);
      repeat (h) @(negedge clk);
      set_sig(1'b0);
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    q8.delete(); q4.delete(); tq8.delete(); tq4.delete(); rise_q.delete();
  endtask

  // One-cycle disable, then re-enable with sig_in low: a fresh acquisition.
  task automatic restart();
    @(negedge clk);
    meas_en = 1'b0;
    sig_in  = 1'b0;
    @(negedge clk);
    clear_logs();
    meas_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // A closing rise publishes the last full period before checks are made.
  task automatic close_rise();
    set_sig(1'b1);
    repeat (4) @(negedge clk);
  endtask

  row_t rows[7];
  int   p4_s, h4_s;

  initial begin
    rows[0] = '{4, 4, 5,  8, 4, 5, 0};
    rows[1] = '{3, 5, 4,  8, 3, 4, 0};
    rows[2] = '{1, 1, 6,  2, 1, 6, 0};
    rows[3] = '{7, 8, 3, 15, 7, 3, 0};
    rows[4] = '{8, 8, 3, 16, 8, 0, 3};
    rows[5] = '{1, 9, 3, 10, 1, 3, 0};
    rows[6] = '{9, 1, 3, 10, 9, 3, 0};

    rst = 1'b1; meas_en = 1'b0; sig_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_dut8", int'({p8, h8, v8, t8}), 0);
    check("reset_outputs_dut4", int'({p4, h4, v4, t4}), 0);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      restart();
      drive_wave(rows[r].h, rows[r].l, rows[r].n);
      close_rise();
      check($sformatf("row%0d_valid_count8", r), q8.size(), rows[r].n);
      for (int i = 0; i < q8.size(); i++) begin
        check($sformatf("row%0d_period8_%0d", r, i), q8[i].p, rows[r].exp_p);
        check($sformatf("row%0d_high8_%0d", r, i), q8[i].h, rows[r].exp_h);
      end
      if (q8.size() > 1) begin
        check($sformatf("row%0d_first_valid_cycle8", r), q8[0].cyc, rise_q[1] + 3);
        check($sformatf("row%0d_valid_spacing8", r), q8[1].cyc - q8[0].cyc, rows[r].exp_p);
      end
      check($sformatf("row%0d_timeout_count8", r), tq8.size(), 0);
      check($sformatf("row%0d_valid_count4", r), q4.size(), rows[r].n4v);
      check($sformatf("row%0d_timeout_count4", r), tq4.size(), rows[r].n4t);
      for (int i = 0; i < q4.size(); i++) begin
        check($sformatf("row%0d_period4_%0d", r, i), q4[i].p, rows[r].exp_p);
        check($sformatf("row%0d_high4_%0d", r, i), q4[i].h, rows[r].exp_h);
      end
    end

    // Pattern change without disable: new values from the 2nd rise of the new pattern.
    restart();
    drive_wave(3, 5, 4);
    drive_wave(1, 1, 4);
    close_rise();
    check("switch_valid_count", q8.size(), 8);
    if (q8.size() == 8) begin
      check("switch_old_period", q8[3].p, 8);
      check("switch_old_high", q8[3].h, 3);
      check("switch_new_cycle", q8[4].cyc, rise_q[5] + 3);
      for (int i = 4; i < 8; i++) begin
        check($sformatf("switch_new_period_%0d", i), q8[i].p, 2);
        check($sformatf("switch_new_high_%0d", i), q8[i].h, 1);
      end
    end

    // 4-bit instance: single rise then held high saturates and re-arms.
    p4_s = int'(p4);
    h4_s = int'(h4);
    restart();
    set_sig(1'b1);
    repeat (30) @(negedge clk);
    check("sat_timeout_count", tq4.size(), 1);
    if (tq4.size() > 0) check("sat_timeout_cycle", tq4[0], rise_q[0] + 18);
    check("sat_no_valid", q4.size(), 0);
    check("sat_period_hold", int'(p4), p4_s);
    check("sat_high_hold", int'(h4), h4_s);
    set_sig(1'b0);
    repeat (3) @(negedge clk);
    drive_wave(3, 3, 3);
    close_rise();
    check("rearm_valid_count", q4.size(), 3);
    if (q4.size() > 0) begin
      check("rearm_first_valid_cycle", q4[0].cyc, rise_q[2] + 3);
      check("rearm_period", q4[0].p, 6);
      check("rearm_high", q4[0].h, 3);
    end
    check("rearm_timeout_count", tq4.size(), 1);

    // Single-cycle disable mid-period aborts that period.
    restart();
    drive_wave(5, 5, 3);
    set_sig(1'b1);
    repeat (5) @(negedge clk);
    set_sig(1'b0);
    repeat (2) @(negedge clk);
    meas_en = 1'b0;
    @(negedge clk);
    meas_en = 1'b1;
    check("drop_valid_count_before", q8.size(), 3);
    check("drop_period_hold", int'(p8), 10);
    check("drop_high_hold", int'(h8), 5);
    check("drop_valid_low", int'(v8), 0);
    repeat (2) @(negedge clk);
    drive_wave(5, 5, 2);
    close_rise();
    check("drop_valid_count_after", q8.size(), 5);
    if (q8.size() == 5) begin
      check("drop_reacquire_cycle", q8[3].cyc, rise_q[5] + 3);
      check("drop_reacquire_period", q8[3].p, 10);
      check("drop_reacquire_high", q8[3].h, 5);
    end

    // Asynchronous reset between clock edges mid-measurement.
    restart();
    drive_wave(4, 4, 3);
    repeat (2) @(negedge clk);
    check("pre_rst_period", int'(p8), 8);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dut8", int'({p8, h8, v8, t8}), 0);
    check("async_rst_dut4", int'({p4, h4, v4, t4}), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    drive_wave(4, 4, 3);
    close_rise();
    check("post_rst_valid_count", q8.size(), 3);
    if (q8.size() > 0) begin
      check("post_rst_first_cycle", q8[0].cyc, rise_q[1] + 3);
      check("post_rst_period", q8[0].p, 8);
      check("post_rst_high", q8[0].h, 4);
    end

    check("valid_timeout_overlap", overlap, 0);
    check("pulse_longer_than_one", runs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
